// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_pkg
//  Description : Shared types and helpers for the iterative RV32M
//                multiply/divide unit (op codes, FSM states, conditional
//                two's-complement negate).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_muldiv_pkg;

    // Working width of the negate helper. Callers zero-extend into it and
    // truncate back, so any DATA_WIDTH up to 64 (product up to 128) works.
    localparam int unsigned C_NEG_WIDTH = 128;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // Two's-complement negate when 'negate' is set; used both to take
    // operand magnitudes and to restore the sign of the result.
    function automatic logic [C_NEG_WIDTH-1:0] cond_negate(
        input logic [C_NEG_WIDTH-1:0] value,
        input logic                   negate
    );
        return negate ? (-value) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit (MSB of the quotient register) into the
//                partial remainder, trial-subtracts the divisor and shifts the
//                resulting quotient bit in at the bottom.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rem,
    input  logic [DATA_WIDTH-1:0] i_quo,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic [DATA_WIDTH-1:0] o_quo
);
    import alu_muldiv_pkg::*;

    logic [DATA_WIDTH:0] w_shifted;
    logic [DATA_WIDTH:0] w_diff;

    // Trial subtract; a set MSB of the difference means a borrow, so restore.
    always_comb begin
        w_shifted = {i_rem, i_quo[DATA_WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        if (w_diff[DATA_WIDTH]) begin
            o_rem = w_shifted[DATA_WIDTH-1:0];
            o_quo = {i_quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            o_rem = w_diff[DATA_WIDTH-1:0];
            o_quo = {i_quo[DATA_WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Multi-cycle RV32M execution unit. Radix-2 shift-add
//                multiplier and restoring divider working on operand
//                magnitudes, with a valid/ready handshake on both sides.
//                Divide-by-zero and signed overflow finish in one cycle.
//                Build option MULDIV_FAST_MUL_EN: multiplies are computed
//                combinationally at accept and also finish in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic [2:0]            MulDivOp_i,
    input  logic                  Flush_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [DATA_WIDTH-1:0] Result_o,
    output logic                  Zero_o
);
    import alu_muldiv_pkg::*;

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    muldiv_state_e           r_state;
    muldiv_state_e           w_next_state;
    muldiv_op_e              r_op;
    logic                    r_neg;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [PROD_WIDTH-1:0]   r_acc;     // mul: {high, multiplier/low}; div: {remainder, quotient}
    logic [DATA_WIDTH-1:0]   r_opnd;    // mul: multiplicand; div: divisor
    logic [DATA_WIDTH-1:0]   r_result;

    muldiv_op_e              w_op;
    logic                    w_accept;
    logic                    w_is_div;
    logic                    w_is_rem;
    logic                    w_a_neg;
    logic                    w_b_neg;
    logic                    w_sign;
    logic [DATA_WIDTH-1:0]   w_a_mag;
    logic [DATA_WIDTH-1:0]   w_b_mag;
    logic                    w_short;
    logic [DATA_WIDTH-1:0]   w_short_result;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [PROD_WIDTH-1:0]   w_mul_next;
    logic [PROD_WIDTH-1:0]   w_acc_next;
    logic [PROD_WIDTH-1:0]   w_prod;
    logic [DATA_WIDTH-1:0]   w_div_rem;
    logic [DATA_WIDTH-1:0]   w_div_quo;
    logic [DATA_WIDTH-1:0]   w_final_result;
    logic                    w_busy_div;

    assign w_op     = muldiv_op_e'(MulDivOp_i);
    assign w_accept = (r_state == IDLE) && Valid_i && !Flush_i;

    // Decode the incoming request: operand signedness, magnitudes, sign flag
    always_comb begin
        w_is_div = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_is_rem = (w_op == OP_REM) || (w_op == OP_REMU);
        w_a_neg  = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA_i[DATA_WIDTH-1];
        w_b_neg  = (w_op inside {OP_MULH, OP_DIV, OP_REM}) && SrcB_i[DATA_WIDTH-1];
        w_a_mag  = DATA_WIDTH'(cond_negate(C_NEG_WIDTH'(SrcA_i), w_a_neg));
        w_b_mag  = DATA_WIDTH'(cond_negate(C_NEG_WIDTH'(SrcB_i), w_b_neg));
        // Remainder follows the dividend; everything else follows a^b.
        w_sign   = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [PROD_WIDTH-1:0] w_fast_prod;
    logic [PROD_WIDTH-1:0] w_fast_signed;
    assign w_fast_prod   = {{DATA_WIDTH{1'b0}}, w_a_mag} * {{DATA_WIDTH{1'b0}}, w_b_mag};
    assign w_fast_signed = PROD_WIDTH'(cond_negate(C_NEG_WIDTH'(w_fast_prod), w_sign));
`endif

    // Requests that bypass iteration and finish in a single cycle
    always_comb begin
        w_short        = 1'b0;
        w_short_result = '0;
        if (w_is_div && (SrcB_i == '0)) begin
            w_short        = 1'b1;
            w_short_result = w_is_rem ? SrcA_i : '1;
        end else if ((w_op == OP_DIV || w_op == OP_REM) &&
                     (SrcA_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (SrcB_i == '1)) begin
            w_short        = 1'b1;
            w_short_result = w_is_rem ? '0 : SrcA_i;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!w_is_div) begin
            w_short        = 1'b1;
            w_short_result = (w_op == OP_MUL) ? w_fast_signed[DATA_WIDTH-1:0]
                                              : w_fast_signed[PROD_WIDTH-1:DATA_WIDTH];
        end
`endif
    end

    // Shift-add multiply iteration: add multiplicand into the high half when
    // the current multiplier bit is set, then shift the whole accumulator right
    assign w_mul_sum  = {1'b0, r_acc[PROD_WIDTH-1:DATA_WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

    muldiv_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[PROD_WIDTH-1:DATA_WIDTH]),
        .i_quo     (r_acc[DATA_WIDTH-1:0]),
        .i_divisor (r_opnd),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_busy_div = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_acc_next = w_busy_div ? {w_div_rem, w_div_quo} : w_mul_next;

    // Re-apply the sign and pick the requested half/part after the last step
    always_comb begin
        w_final_result = '0;
        w_prod         = PROD_WIDTH'(cond_negate(C_NEG_WIDTH'(w_acc_next), r_neg));
        case (r_op)
            OP_MUL:                       w_final_result = w_prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final_result = w_prod[PROD_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:              w_final_result = DATA_WIDTH'(cond_negate(C_NEG_WIDTH'(w_div_quo), r_neg));
            default:                      w_final_result = DATA_WIDTH'(cond_negate(C_NEG_WIDTH'(w_div_rem), r_neg));
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush outranks accept and completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_short ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (Flush_i) begin
                    w_next_state = IDLE;
                end else if (r_cnt == CNT_WIDTH'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (Flush_i || Ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        Ready_o = (r_state == IDLE);
        Valid_o = (r_state == DONE);
    end

    // Datapath: latch request at accept, iterate in BUSY, capture result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_neg <= w_sign;
            if (w_short) begin
                r_cnt    <= '0;
                r_result <= w_short_result;
            end else begin
                r_cnt  <= CNT_WIDTH'(DATA_WIDTH);
                r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                r_acc  <= {{DATA_WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            end
        end else if (r_state == BUSY) begin
            if (Flush_i) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt - CNT_WIDTH'(1);
                if (r_cnt == CNT_WIDTH'(1)) begin
                    r_result <= w_final_result;
                end
            end
        end
    end

    assign Result_o = r_result;
    assign Zero_o   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_iter
//  Description : Self-checking bench for alu_muldiv_iter. A driver issues
//                directed operations and pushes hand-computed results into a
//                scoreboard; a monitor pops and compares when Valid_o rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_iter;

    localparam int DW = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = DW + 1;
`endif
    localparam int LAT_DIV = DW + 1;
    localparam int LAT_SPC = 1;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          Valid_i;
    logic          Ready_o;
    logic [DW-1:0] SrcA_i;
    logic [DW-1:0] SrcB_i;
    logic [2:0]    MulDivOp_i;
    logic          Flush_i;
    logic          Valid_o;
    logic          Ready_i;
    logic [DW-1:0] Result_o;
    logic          Zero_o;

    alu_muldiv_iter #(.DATA_WIDTH(DW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .Valid_i    (Valid_i),
        .Ready_o    (Ready_o),
        .SrcA_i     (SrcA_i),
        .SrcB_i     (SrcB_i),
        .MulDivOp_i (MulDivOp_i),
        .Flush_i    (Flush_i),
        .Valid_o    (Valid_o),
        .Ready_i    (Ready_i),
        .Result_o   (Result_o),
        .Zero_o     (Zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] result;
        logic          zero;
        int            lat;
        int            acc_cyc;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request for exactly one cycle; optionally register its expectation
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_res, input int lat, input string name,
                         input bit push);
        exp_t e;
        @(negedge clk_i);
        Valid_i    = 1'b1;
        MulDivOp_i = op;
        SrcA_i     = a;
        SrcB_i     = b;
        if (push) begin
            e.result  = exp_res;
            e.zero    = (exp_res == '0);
            e.lat     = lat;
            e.acc_cyc = cyc;
            e.name    = name;
            sb_q.push_back(e);
        end
        @(negedge clk_i);
        // Scramble inputs after accept; the unit must ignore them
        Valid_i    = 1'b0;
        MulDivOp_i = 3'b011;
        SrcA_i     = 32'hDEAD_BEEF;
        SrcB_i     = 32'h0000_0000;
    endtask

    task automatic wait_done(input string name);
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 200) begin
            @(negedge clk_i);
            k++;
            ok = (sb_q.size() == 0) && Ready_o;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_res, input int lat, input string name);
        issue(op, a, b, exp_res, lat, name, 1'b1);
        wait_done(name);
    endtask

    // Monitor: compare each new result against the oldest expectation
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_v = 1'b0;
            end else begin
                if (Valid_o && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got Valid_o=1 result 0x%08h, expected no result", Result_o);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_result"}, Result_o, e.result);
                        check({e.name, "_zero"}, DW'(Zero_o), DW'(e.zero));
                        check({e.name, "_latency"}, DW'(cyc - e.acc_cyc), DW'(e.lat));
                    end
                end
                prev_v = Valid_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int k;
        int vcount;
        rst_i      = 1'b1;
        Valid_i    = 1'b0;
        Ready_i    = 1'b1;
        Flush_i    = 1'b0;
        SrcA_i     = '0;
        SrcB_i     = '0;
        MulDivOp_i = 3'b000;
        repeat (3) @(negedge clk_i);
        check("reset_ready", DW'(Ready_o), 32'd1);
        check("reset_valid", DW'(Valid_o), 32'd0);
        check("reset_result", Result_o, 32'd0);
        check("reset_zero", DW'(Zero_o), 32'd1);
        rst_i = 1'b0;

        // Multiply
        run(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL, "mul_7_m3");
        run(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL, "mulh_min_min");
        run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL, "mulhsu_m1");
        run(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL, "mulhu_max");
        run(MUL,    32'd0,        32'h0001_2345, 32'd0,         LAT_MUL, "mul_zero");

        // Divide
        run(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_DIV, "div_m7_2");
        run(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_DIV, "rem_m7_2");
        run(DIVU, 32'd100,       32'd7,         32'd14,        LAT_DIV, "divu_100_7");
        run(REMU, 32'd100,       32'd7,         32'd2,         LAT_DIV, "remu_100_7");
        run(DIV,  32'd1000,      32'hFFFF_FFFD, 32'hFFFF_FEB3, LAT_DIV, "div_1000_m3");
        run(REM,  32'd1000,      32'hFFFF_FFFD, 32'd1,         LAT_DIV, "rem_1000_m3");
        run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_DIV, "divu_big");
        run(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_DIV, "remu_big");

        // Single-cycle special cases
        run(DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPC, "divu_by0");
        run(REMU, 32'd5,         32'd0,         32'd5,         LAT_SPC, "remu_by0");
        run(DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPC, "div_by0");
        run(REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SPC, "rem_by0");
        run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC, "div_ovf");
        run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPC, "rem_ovf");

        // Backpressure: result must hold while Ready_i is low
        Ready_i = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 32'd14, LAT_DIV, "bp_divu", 1'b1);
        k = 0;
        while (!Valid_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_hold", DW'(Valid_o), 32'd1);
            check("bp_result_hold", Result_o, 32'd14);
            check("bp_ready_low", DW'(Ready_o), 32'd0);
            @(negedge clk_i);
        end
        Ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_ready_after", DW'(Ready_o), 32'd1);
        check("bp_valid_after", DW'(Valid_o), 32'd0);
        wait_done("bp_divu");

        // Flush in BUSY cycle 5: back to IDLE, no result ever
        issue(MUL, 32'd7, 32'd3, 32'd21, LAT_MUL, "flush_busy", 1'b0);
        repeat (4) @(negedge clk_i);
        Flush_i = 1'b1;
        @(negedge clk_i);
        Flush_i = 1'b0;
        check("flush_busy_ready", DW'(Ready_o), 32'd1);
        check("flush_busy_valid", DW'(Valid_o), 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (Valid_o) vcount++;
        end
        check("flush_busy_no_valid", DW'(vcount), 32'd0);

        // Flush while a request is presented in IDLE: not accepted
        @(negedge clk_i);
        Valid_i    = 1'b1;
        Flush_i    = 1'b1;
        MulDivOp_i = DIVU;
        SrcA_i     = 32'd5;
        SrcB_i     = 32'd0;
        @(negedge clk_i);
        Valid_i = 1'b0;
        Flush_i = 1'b0;
        check("flush_idle_ready", DW'(Ready_o), 32'd1);
        check("flush_idle_valid", DW'(Valid_o), 32'd0);
        vcount = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (Valid_o) vcount++;
        end
        check("flush_idle_no_valid", DW'(vcount), 32'd0);

        // Reset in the middle of a divide, then a clean divide
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV, "rst_mid", 1'b0);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_ready", DW'(Ready_o), 32'd1);
        check("rst_mid_valid", DW'(Valid_o), 32'd0);
        check("rst_mid_result", Result_o, 32'd0);
        check("rst_mid_zero", DW'(Zero_o), 32'd1);
        rst_i = 1'b0;
        run(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV, "div_after_rst");
        run(MULHU, 32'd3, 32'd5, 32'd0, LAT_MUL, "mulhu_small");

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
